calc1_req_scheduler: RTL and testbench
======================================

Name: calc1_req_scheduler

Overview:
Front-end scheduler that lets four independent request ports share one pipelined calc1 arithmetic unit. Each port uses the calc1 two-cycle protocol: command plus operand 1 in one cycle, operand 2 in the next. The block captures each port's request, grants the shared ALU round-robin at up to one operation per cycle, and routes each result back to the originating port's out_data/out_resp for exactly one cycle.

Parameters:
ALU_LAT, 2, pipeline depth of the shared ALU in cycles (1..4)
DATA_W, 32, operand/result width

Ports:
c_clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req1_cmd_in..req4_cmd_in  in  4 each ([0:3])  per-port command
req1_data_in..req4_data_in  in  32 each ([0:31])  per-port operand
out_data1..out_data4  out  32 each ([0:31])  per-port result
out_resp1..out_resp4  out  2 each ([0:1])  per-port response code
port_busy  out  4 ([0:3])  bit i-1 high while port i is in OP2 or PEND

Behaviour:
- Commands: 0 = none, 1 = add, 2 = sub, 5 = shift left, 6 = shift right. All other values are invalid.
- Response codes: 0 = no response, 1 = success, 2 = overflow/underflow/invalid command. Code 3 is never driven.
- Reset: every port FSM goes to IDLE, the ALU pipeline is flushed and the round-robin pointer is set to port 4, so port 1 wins first. All out_data, out_resp and port_busy are 0 in the cycle after reset is sampled high.
- Reset mid-operation: every captured and in-flight operation is discarded. No response is ever produced for a discarded operation.
- Per-port FSM:
  - IDLE: nonzero cmd -> capture cmd and op1 -> OP2.
  - OP2: capture data as op2 -> PEND. cmd is ignored in this cycle.
  - PEND: wait for grant. When granted -> IDLE in the next cycle. Any nonzero cmd seen in PEND is dropped silently.
- Arbitration:
  - Each cycle, at most one PEND port is granted.
  - Search starts at the port after the last grant, wrapping 4 -> 1.
  - The pointer updates only when a grant is made.
- Latency: with cmd sampled in cycle T and the port granted uncontended, the response is valid in cycle T+2+ALU_LAT (T+4 at default).
  - Each cycle of contention adds one cycle.
  - Responses are registered, last exactly one cycle, and are 0 in every other cycle.
- A port may issue a new command while its previous op is still in the pipeline. Ordering is preserved because the pipeline is in-order, one op per cycle, so two responses on one port never collide.
- Arithmetic (unsigned 32-bit):
  - add: carry out -> resp 2, data 0.
  - sub: op2 > op1 -> resp 2, data 0.
  - shifts: amount = op2 bits [27:31] (low 5 bits), zero fill, resp 1.
  - invalid cmd: resp 2, data 0, same latency as a valid op.
- Pipeline entries carry a 2-bit port tag plus a valid bit. A bubble yields no response.

Decomposition:
- Package calc1_pkg holds:
  - command and response encodings
  - NUM_PORTS = 4 and DATA_W
  - port-FSM state enum
  - request struct {cmd, op1, op2}
- Sub-module calc1_alu_pipe:
  - inputs: valid, tag, cmd, op1, op2
  - outputs: ALU_LAT-stage registered valid, tag, data and resp
  - flushed by reset
- The scheduler instantiates the pipe once and demuxes results by tag.

Test Plan:
1. Port 1 cmd 1 with 0x0000_0001 in cycle T, then 0x1FFF_FFFF in T+1 -> out_data1 = 0x2000_0000, out_resp1 = 1 in T+4 only; other ports resp 0.
2. Port 2 add 0xFFFF_FFFF + 1 -> out_resp2 = 2, out_data2 = 0. Port 3 sub 1 - 15 -> out_resp3 = 2, out_data3 = 0.
3. All four ports issue sub 5 - 3 in the same cycle T -> data 2, resp 1 on port 1 at T+4, port 2 at T+5, port 3 at T+6, port 4 at T+7. port_busy bits clear in grant order.
4. Port 1 shl 1 by 31 -> 0x8000_0000. Port 1 shr 0x8000_0000 by 31 -> 0x0000_0001. Port 4 cmd 3 and cmd 4 -> resp 2, data 0.
5. Port 1 add in progress; reset asserted at T+3 -> no response on port 1, all outputs 0. After release, port 1 add 2 + 2 -> 4, resp 1, with port 1 winning over a simultaneous port 3 request.
6. Port 2 issues a new cmd while in PEND -> dropped, only the first result returns. Port 2 back-to-back requests after grant -> two responses in order, one cycle each.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared encodings, widths and the arithmetic helper for the calc1 request scheduler.
// The ALU result function lives here so the pipe stage stays a plain register chain.
package calc1_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 32;
    localparam int CMD_W     = 4;
    localparam int TAG_W     = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NONE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_PEND
    } port_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    // Returns {resp, data}; any error (carry, borrow, bad cmd) forces data to zero.
    function automatic logic [DATA_W+1:0] alu_eval(input logic [CMD_W-1:0]  cmd,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   sum;
        logic [DATA_W+1:0] r;
        sum = {1'b0, a} + {1'b0, b};
        r   = {RESP_ERR, {DATA_W{1'b0}}};
        case (cmd)
            CMD_ADD: if (!sum[DATA_W]) r = {RESP_OK, sum[DATA_W-1:0]};
            CMD_SUB: if (b <= a)       r = {RESP_OK, a - b};
            CMD_SHL: r = {RESP_OK, a << b[4:0]};
            CMD_SHR: r = {RESP_OK, a >> b[4:0]};
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc1_alu_pipe.sv
// Shared calc1 ALU: result computed at the input, then carried through ALU_LAT
// registered stages together with the originating port tag.
module calc1_alu_pipe import calc1_pkg::*; #(
    parameter int ALU_LAT = 2
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_resp
);

    logic [ALU_LAT-1:0]                 vld_pipe;
    logic [ALU_LAT-1:0][TAG_W-1:0]      tag_pipe;
    logic [ALU_LAT-1:0][DATA_W+1:0]     res_pipe;

    // Only the valid chain is flushed; a bubble's stale tag/data are never observed.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            for (int s = 1; s < ALU_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
        tag_pipe[0] <= in_tag;
        res_pipe[0] <= alu_eval(in_cmd, in_op1, in_op2);
        for (int s = 1; s < ALU_LAT; s++) begin
            tag_pipe[s] <= tag_pipe[s-1];
            res_pipe[s] <= res_pipe[s-1];
        end
    end

    assign out_valid = vld_pipe[ALU_LAT-1];
    assign out_tag   = tag_pipe[ALU_LAT-1];
    assign out_resp  = res_pipe[ALU_LAT-1][DATA_W+1:DATA_W];
    assign out_data  = res_pipe[ALU_LAT-1][DATA_W-1:0];

endmodule

// File: rtl/calc1_req_scheduler.sv
// Four calc1 request ports sharing one pipelined ALU: per-port two-cycle capture,
// round-robin grant of one PEND port per cycle, results demuxed back by tag.
module calc1_req_scheduler import calc1_pkg::*; #(
    parameter int ALU_LAT = 2
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req1_cmd_in,
    input  logic [CMD_W-1:0]  req2_cmd_in,
    input  logic [CMD_W-1:0]  req3_cmd_in,
    input  logic [CMD_W-1:0]  req4_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic [1:0]        out_resp1,
    output logic [1:0]        out_resp2,
    output logic [1:0]        out_resp3,
    output logic [1:0]        out_resp4,
    output logic [NUM_PORTS-1:0] port_busy
);

    logic [NUM_PORTS-1:0][CMD_W-1:0]  cmd_in;
    logic [NUM_PORTS-1:0][DATA_W-1:0] data_in;

    assign cmd_in  = {req4_cmd_in, req3_cmd_in, req2_cmd_in, req1_cmd_in};
    assign data_in = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};

    port_state_e [NUM_PORTS-1:0] state_q, state_d;
    req_t        [NUM_PORTS-1:0] req_q, req_d;
    logic        [TAG_W-1:0]     ptr_q;

    logic                        gnt_valid;
    logic        [TAG_W-1:0]     gnt_idx;
    logic        [TAG_W-1:0]     cand;

    // Search begins one past the last winner; k = NUM_PORTS wraps back to ptr_q itself.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = ptr_q + TAG_W'(k);
            if (!gnt_valid && state_q[cand] == ST_PEND) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (state_q[p])
                ST_IDLE: begin
                    if (cmd_in[p] != CMD_NONE) begin
                        req_d[p].cmd = cmd_in[p];
                        req_d[p].op1 = data_in[p];
                        state_d[p]   = ST_OP2;
                    end
                end
                ST_OP2: begin
                    req_d[p].op2 = data_in[p];
                    state_d[p]   = ST_PEND;
                end
                ST_PEND: begin
                    if (gnt_valid && gnt_idx == TAG_W'(p)) state_d[p] = ST_IDLE;
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ST_IDLE;
            ptr_q <= TAG_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            if (gnt_valid) ptr_q <= gnt_idx;
        end
        req_q <= req_d;
    end

    always_comb begin
        port_busy = '0;
        for (int p = 0; p < NUM_PORTS; p++) port_busy[p] = (state_q[p] != ST_IDLE);
    end

    logic              pipe_valid;
    logic [TAG_W-1:0]  pipe_tag;
    logic [DATA_W-1:0] pipe_data;
    logic [1:0]        pipe_resp;

    calc1_alu_pipe #(.ALU_LAT(ALU_LAT)) u_alu_pipe (
        .c_clk     (c_clk),
        .reset     (reset),
        .in_valid  (gnt_valid),
        .in_tag    (gnt_idx),
        .in_cmd    (req_q[gnt_idx].cmd),
        .in_op1    (req_q[gnt_idx].op1),
        .in_op2    (req_q[gnt_idx].op2),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data),
        .out_resp  (pipe_resp)
    );

    // Outputs are gated straight off the final pipe register, so they hold for one cycle only.
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_data;
    logic [NUM_PORTS-1:0][1:0]        rsp_code;

    always_comb begin
        rsp_data = '0;
        rsp_code = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pipe_valid && pipe_tag == TAG_W'(p)) begin
                rsp_data[p] = pipe_data;
                rsp_code[p] = pipe_resp;
            end
        end
    end

    assign out_data1 = rsp_data[0];
    assign out_data2 = rsp_data[1];
    assign out_data3 = rsp_data[2];
    assign out_data4 = rsp_data[3];
    assign out_resp1 = rsp_code[0];
    assign out_resp2 = rsp_code[1];
    assign out_resp3 = rsp_code[2];
    assign out_resp4 = rsp_code[3];

endmodule

// File: tb/tb_calc1_req_scheduler.sv
// Directed bench for calc1_req_scheduler: a transaction-level model scores every
// cycle, and literal expectations pin key results of the directed scenarios.
module tb_calc1_req_scheduler;

    localparam int ALU_LAT = 2;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd  [4];
    logic [31:0] dat  [4];
    logic [31:0] dout [4];
    logic [1:0]  rout [4];
    logic [3:0]  busy;

    always #5 c_clk = ~c_clk;

    calc1_req_scheduler #(.ALU_LAT(ALU_LAT)) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd[0]),
        .req2_cmd_in  (cmd[1]),
        .req3_cmd_in  (cmd[2]),
        .req4_cmd_in  (cmd[3]),
        .req1_data_in (dat[0]),
        .req2_data_in (dat[1]),
        .req3_data_in (dat[2]),
        .req4_data_in (dat[3]),
        .out_data1    (dout[0]),
        .out_data2    (dout[1]),
        .out_data3    (dout[2]),
        .out_data4    (dout[3]),
        .out_resp1    (rout[0]),
        .out_resp2    (rout[1]),
        .out_resp3    (rout[2]),
        .out_resp4    (rout[3]),
        .port_busy    (busy)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Expected {resp,data} keyed by cycle*4+port; absent key means 0/0.
    logic [33:0] exp_q [int];
    logic [33:0] lit_q [int];
    logic [3:0]  lit_busy [int];
    logic [3:0]  exp_busy = 4'b0;

    // Model: per-port request record plus a round-robin "last winner".
    int          m_phase [4];
    logic [3:0]  m_cmd   [4];
    logic [31:0] m_a     [4];
    logic [31:0] m_b     [4];
    int          m_last = 3;
    int          m_gnt;
    int          m_q;
    int          stale [$];

    function automatic logic [33:0] model_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        logic [31:0] amt;
        amt = b % 32;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, a + b};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5: return {2'd1, a << amt};
            4'd6: return {2'd1, a >> amt};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    always @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) m_phase[p] = 0;
            m_last = 3;
            stale.delete();
            foreach (exp_q[k]) if (k / 4 > cyc) stale.push_back(k);
            foreach (stale[i]) exp_q.delete(stale[i]);
        end else begin
            m_gnt = -1;
            for (int k = 1; k <= 4; k++) begin
                m_q = (m_last + k) % 4;
                if (m_gnt < 0 && m_phase[m_q] == 2) m_gnt = m_q;
            end
            if (m_gnt >= 0) begin
                exp_q[(cyc + ALU_LAT) * 4 + m_gnt] = model_calc(m_cmd[m_gnt], m_a[m_gnt], m_b[m_gnt]);
                m_last = m_gnt;
            end
            for (int p = 0; p < 4; p++) begin
                if (m_phase[p] == 0 && cmd[p] != 4'd0) begin
                    m_cmd[p] = cmd[p]; m_a[p] = dat[p]; m_phase[p] = 1;
                end else if (m_phase[p] == 1) begin
                    m_b[p] = dat[p]; m_phase[p] = 2;
                end else if (m_phase[p] == 2 && p == m_gnt) begin
                    m_phase[p] = 0;
                end
            end
        end
        for (int p = 0; p < 4; p++) exp_busy[p] = (m_phase[p] != 0);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int p, input logic [33:0] act, input logic [33:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s port%0d cyc%0d got %h want %h", name, p + 1, cyc, act, want);
    endtask

    always @(negedge c_clk) begin
        if (cyc >= 1) begin
            for (int p = 0; p < 4; p++) begin
                check("model_out", p, {rout[p], dout[p]}, exp_q.exists(cyc*4+p) ? exp_q[cyc*4+p] : 34'd0);
                if (lit_q.exists(cyc*4+p)) check("literal_out", p, {rout[p], dout[p]}, lit_q[cyc*4+p]);
            end
            check("model_busy", -1, {30'd0, busy}, {30'd0, exp_busy});
            if (lit_busy.exists(cyc)) check("literal_busy", -1, {30'd0, busy}, {30'd0, lit_busy[cyc]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge c_clk);
    endtask

    task automatic clr();
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; dat[p] = 32'd0; end
    endtask

    task automatic lit(input int p, input int c, input logic [31:0] d, input logic [1:0] r);
        lit_q[c*4+p] = {r, d};
    endtask

    // Single uncontended op: result only at T+4, silent just before and after.
    task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic [1:0] er);
        int t;
        t = cyc;
        cmd[p] = c; dat[p] = a; tick(1);
        cmd[p] = 4'd0; dat[p] = b; tick(1);
        clr();
        lit(p, t + 3, 32'd0, 2'd0);
        lit(p, t + 4, ed, er);
        lit(p, t + 5, 32'd0, 2'd0);
        tick(5);
    endtask

    initial begin
        int t;
        clr();
        for (int p = 0; p < 4; p++) lit(p, 1, 32'd0, 2'd0);
        lit_busy[1] = 4'b0000;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Basic add, add overflow, add at the carry boundary
        run_op(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 32'h2000_0000, 2'd1);
        run_op(0, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 2'd1);

        // Port 2 add overflow and port 3 sub underflow together
        t = cyc;
        cmd[1] = 4'd1; dat[1] = 32'hFFFF_FFFF;
        cmd[2] = 4'd2; dat[2] = 32'd1;
        tick(1);
        cmd[1] = 4'd0; dat[1] = 32'd1;
        cmd[2] = 4'd0; dat[2] = 32'd15;
        tick(1); clr();
        lit(1, t + 4, 32'd0, 2'd2);
        lit(2, t + 5, 32'd0, 2'd2);
        tick(6);

        // Invalid commands on port 4 (also leaves the pointer on port 4)
        run_op(3, 4'd3, 32'd9, 32'd9, 32'd0, 2'd2);
        run_op(3, 4'd4, 32'd9, 32'd9, 32'd0, 2'd2);

        // Four-way contention: grant order 1,2,3,4
        t = cyc;
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd2; dat[p] = 32'd5; end
        tick(1);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; dat[p] = 32'd3; end
        tick(1); clr();
        for (int p = 0; p < 4; p++) lit(p, t + 4 + p, 32'd2, 2'd1);
        lit_busy[t+2] = 4'b1111;
        lit_busy[t+3] = 4'b1110;
        lit_busy[t+4] = 4'b1100;
        lit_busy[t+5] = 4'b1000;
        lit_busy[t+6] = 4'b0000;
        tick(8);

        // Shifts, including a shift amount taken from the low 5 bits only
        run_op(0, 4'd5, 32'h0000_0001, 32'd31, 32'h8000_0000, 2'd1);
        run_op(0, 4'd6, 32'h8000_0000, 32'd31, 32'h0000_0001, 2'd1);
        run_op(1, 4'd5, 32'h0000_0003, 32'd33, 32'h0000_0006, 2'd1);
        run_op(2, 4'd2, 32'd7, 32'd7, 32'd0, 2'd1);

        // Reset during an in-flight op discards it
        t = cyc;
        cmd[0] = 4'd1; dat[0] = 32'd1; tick(1);
        cmd[0] = 4'd0; dat[0] = 32'd1; tick(1);
        clr(); tick(1);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        lit(0, t + 4, 32'd0, 2'd0);
        lit_busy[t+4] = 4'b0000;
        tick(2);

        // After reset port 1 wins over port 3
        t = cyc;
        cmd[0] = 4'd1; dat[0] = 32'd2;
        cmd[2] = 4'd1; dat[2] = 32'd2;
        tick(1);
        cmd[0] = 4'd0; cmd[2] = 4'd0;
        tick(1); clr();
        lit(0, t + 4, 32'd4, 2'd1);
        lit(2, t + 4, 32'd0, 2'd0);
        lit(2, t + 5, 32'd4, 2'd1);
        tick(6);

        // Command during PEND is dropped
        t = cyc;
        cmd[1] = 4'd1; dat[1] = 32'd10; tick(1);
        cmd[1] = 4'd0; dat[1] = 32'd20; tick(1);
        cmd[1] = 4'd1; dat[1] = 32'd7;  tick(1);
        cmd[1] = 4'd0; dat[1] = 32'd8;  tick(1);
        clr();
        lit(1, t + 4, 32'd30, 2'd1);
        lit(1, t + 5, 32'd0, 2'd0);
        lit(1, t + 6, 32'd0, 2'd0);
        lit(1, t + 7, 32'd0, 2'd0);
        tick(6);

        // Back-to-back requests on port 2 right after its grant
        t = cyc;
        cmd[1] = 4'd1; dat[1] = 32'd1; tick(1);
        cmd[1] = 4'd0; dat[1] = 32'd2; tick(1);
        clr(); tick(1);
        cmd[1] = 4'd1; dat[1] = 32'd3; tick(1);
        cmd[1] = 4'd0; dat[1] = 32'd4; tick(1);
        clr();
        lit(1, t + 4, 32'd3, 2'd1);
        lit(1, t + 5, 32'd0, 2'd0);
        lit(1, t + 7, 32'd7, 2'd1);
        lit(1, t + 8, 32'd0, 2'd0);
        tick(8);

        @(posedge c_clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
